// File: rtl/parking_gate_arbiter_pkg.sv
// Shared definitions for the parking gate arbiter: FSM state encoding,
// lane identifiers and the timer width helper.
package parking_gate_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AUTH     = 3'd1,
        ST_OPEN_IN  = 3'd2,
        ST_OPEN_OUT = 3'd3,
        ST_GUARD    = 3'd4
    } state_t;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_t;

    // Width that holds the largest of the three timeouts.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    localparam int DEF_AUTH_CYCLES  = 200;
    localparam int DEF_OPEN_CYCLES  = 50;
    localparam int DEF_GUARD_CYCLES = 10;
    localparam int TMR_W = timer_width(DEF_AUTH_CYCLES, DEF_OPEN_CYCLES, DEF_GUARD_CYCLES);

endpackage

// File: rtl/parking_gate_arbiter_timer.sv
// Loadable down-counter shared by the auth, open and guard timeouts.
// Loading N-1 makes o_expired rise in the Nth cycle after the load.
module parking_gate_arbiter_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    // Count down to zero and hold; a load always takes priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier gate sequencer: arbitrates entrance/exit lanes, drives
// password authentication for entries, times the open and guard windows
// and tracks lot occupancy.
//
//  state       | meaning
//  ------------+--------------------------------------------------------
//  ST_IDLE     | gate closed, arbitrating eligible lane requests
//  ST_AUTH     | waiting for the password verdict (entry only)
//  ST_OPEN_IN  | gate up for the entrance lane, waiting for the car
//  ST_OPEN_OUT | gate up for the exit lane, waiting for the car
//  ST_GUARD    | gate held closed after a pass before the next grant
module parking_gate_arbiter
    import parking_gate_arbiter_pkg::*;
#(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int AUTH_CYCLES  = DEF_AUTH_CYCLES,
    parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_entry_req,
    input  logic             i_exit_req,
    input  logic             i_auth_done,
    input  logic             i_auth_ok,
    input  logic             i_gate_clear,
    output logic             o_auth_start,
    output logic             o_gate_open,
    output logic             o_entry_grant,
    output logic             o_exit_grant,
    output logic             o_deny,
    output logic [CNT_W-1:0] o_occupancy,
    output logic             o_lot_full,
    output logic             o_lot_empty
);

    localparam int               TW    = timer_width(AUTH_CYCLES, OPEN_CYCLES, GUARD_CYCLES);
    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
    localparam logic [TW-1:0]    LD_AUTH  = TW'(AUTH_CYCLES - 1);
    localparam logic [TW-1:0]    LD_OPEN  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0]    LD_GUARD = TW'(GUARD_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    lane_t            r_last_served;
    lane_t            w_served_nxt;
    logic [CNT_W-1:0] w_occ_nxt;
    logic             w_entry_ok;
    logic             w_exit_ok;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_expired;

    parking_gate_arbiter_timer #(.W(TW)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_expired)
    );

    // Next-state, round-robin and occupancy update logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_served_nxt = r_last_served;
        w_occ_nxt    = o_occupancy;
        w_entry_ok   = i_entry_req & ~o_lot_full;
        w_exit_ok    = i_exit_req & ~o_lot_empty;
        case (r_state)
            ST_IDLE: begin
                if (w_entry_ok && w_exit_ok) begin
                    w_state_nxt = (r_last_served == LANE_EXIT) ? ST_AUTH : ST_OPEN_OUT;
                end else if (w_entry_ok) begin
                    w_state_nxt = ST_AUTH;
                end else if (w_exit_ok) begin
                    w_state_nxt = ST_OPEN_OUT;
                end
            end
            ST_AUTH: begin
                if (i_auth_done) begin
                    w_state_nxt = i_auth_ok ? ST_OPEN_IN : ST_IDLE;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OPEN_IN: begin
                if (i_gate_clear || w_expired) begin
                    w_state_nxt  = ST_GUARD;
                    w_served_nxt = LANE_ENTRY;
                    if (i_gate_clear) w_occ_nxt = o_occupancy + CNT_W'(1);
                end
            end
            ST_OPEN_OUT: begin
                if (i_gate_clear || w_expired) begin
                    w_state_nxt  = ST_GUARD;
                    w_served_nxt = LANE_EXIT;
                    if (i_gate_clear) w_occ_nxt = o_occupancy - CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (w_expired) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Reload the shared timer on every state entry with that state's window.
    always_comb begin
        w_tmr_load = (w_state_nxt != r_state);
        case (w_state_nxt)
            ST_AUTH:     w_tmr_val = LD_AUTH;
            ST_OPEN_IN,
            ST_OPEN_OUT: w_tmr_val = LD_OPEN;
            ST_GUARD:    w_tmr_val = LD_GUARD;
            default:     w_tmr_val = '0;
        endcase
    end

    // State, round-robin flag, occupancy and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_last_served <= LANE_EXIT;
            o_auth_start  <= 1'b0;
            o_gate_open   <= 1'b0;
            o_entry_grant <= 1'b0;
            o_exit_grant  <= 1'b0;
            o_deny        <= 1'b0;
            o_occupancy   <= '0;
            o_lot_full    <= 1'b0;
            o_lot_empty   <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_last_served <= w_served_nxt;
            o_auth_start  <= (r_state == ST_IDLE) && (w_state_nxt == ST_AUTH);
            o_deny        <= (r_state == ST_AUTH) && (w_state_nxt == ST_IDLE);
            o_entry_grant <= (w_state_nxt == ST_OPEN_IN);
            o_exit_grant  <= (w_state_nxt == ST_OPEN_OUT);
            o_gate_open   <= (w_state_nxt == ST_OPEN_IN) || (w_state_nxt == ST_OPEN_OUT);
            o_occupancy   <= w_occ_nxt;
            o_lot_full    <= (w_occ_nxt == CAP_V);
            o_lot_empty   <= (w_occ_nxt == '0);
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with hand-computed expectations.
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       auth_done = 1'b0;
    logic       auth_ok = 1'b0;
    logic       gate_clear = 1'b0;
    logic       auth_start;
    logic       gate_open;
    logic       entry_grant;
    logic       exit_grant;
    logic       deny;
    logic [3:0] occupancy;
    logic       lot_full;
    logic       lot_empty;

    int n_checks = 0;
    int n_errors = 0;

    parking_gate_arbiter dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_entry_req   (entry_req),
        .i_exit_req    (exit_req),
        .i_auth_done   (auth_done),
        .i_auth_ok     (auth_ok),
        .i_gate_clear  (gate_clear),
        .o_auth_start  (auth_start),
        .o_gate_open   (gate_open),
        .o_entry_grant (entry_grant),
        .o_exit_grant  (exit_grant),
        .o_deny        (deny),
        .o_occupancy   (occupancy),
        .o_lot_full    (lot_full),
        .o_lot_empty   (lot_empty)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entry with a good password; ends in IDLE after the guard window.
    task automatic do_entry_good(input int exp_occ);
        entry_req = 1'b1;
        tick(1);
        check_val("entry_auth_start", int'(auth_start), 1);
        entry_req = 1'b0;
        tick(1);
        check_val("entry_auth_start_pulse", int'(auth_start), 0);
        auth_done = 1'b1;
        auth_ok   = 1'b1;
        tick(1);
        auth_done = 1'b0;
        check_val("entry_gate_open", int'(gate_open), 1);
        check_val("entry_grant", int'(entry_grant), 1);
        gate_clear = 1'b1;
        tick(1);
        gate_clear = 1'b0;
        check_val("entry_gate_closed", int'(gate_open), 0);
        check_val("entry_occ", int'(occupancy), exp_occ);
        tick(10);
    endtask

    // Exit pass; ends in IDLE after the guard window.
    task automatic do_exit(input int exp_occ);
        exit_req = 1'b1;
        tick(1);
        check_val("exit_grant", int'(exit_grant), 1);
        check_val("exit_no_auth", int'(auth_start), 0);
        exit_req   = 1'b0;
        gate_clear = 1'b1;
        tick(1);
        gate_clear = 1'b0;
        check_val("exit_occ", int'(occupancy), exp_occ);
        tick(10);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick(2);
        check_val("rst_occ", int'(occupancy), 0);
        check_val("rst_empty", int'(lot_empty), 1);
        check_val("rst_full", int'(lot_full), 0);
        check_val("rst_gate", int'(gate_open), 0);
        check_val("rst_auth_start", int'(auth_start), 0);
        check_val("rst_deny", int'(deny), 0);
        reset = 1'b0;

        // Exit request on an empty lot is ignored
        exit_req = 1'b1;
        tick(3);
        check_val("empty_exit_gate", int'(gate_open), 0);
        check_val("empty_exit_grant", int'(exit_grant), 0);
        check_val("empty_exit_deny", int'(deny), 0);
        exit_req = 1'b0;

        // Good entry, then check the guard length with entry held
        entry_req = 1'b1;
        tick(1);
        check_val("e1_auth_start", int'(auth_start), 1);
        entry_req = 1'b0;
        tick(1);
        check_val("e1_auth_pulse", int'(auth_start), 0);
        auth_done = 1'b1;
        auth_ok   = 1'b1;
        tick(1);
        auth_done = 1'b0;
        check_val("e1_gate_open", int'(gate_open), 1);
        check_val("e1_entry_grant", int'(entry_grant), 1);
        check_val("e1_exit_grant", int'(exit_grant), 0);
        gate_clear = 1'b1;
        tick(1);
        gate_clear = 1'b0;
        check_val("e1_occ", int'(occupancy), 1);
        check_val("e1_empty", int'(lot_empty), 0);
        check_val("e1_guard_gate", int'(gate_open), 0);
        entry_req = 1'b1;
        tick(10);
        check_val("guard_hold", int'(auth_start), 0);
        tick(1);
        check_val("guard_release", int'(auth_start), 1);
        entry_req = 1'b0;

        // Bad password
        tick(1);
        auth_done = 1'b1;
        auth_ok   = 1'b0;
        tick(1);
        auth_done = 1'b0;
        check_val("bad_deny", int'(deny), 1);
        check_val("bad_gate", int'(gate_open), 0);
        tick(1);
        check_val("bad_deny_pulse", int'(deny), 0);
        check_val("bad_occ", int'(occupancy), 1);

        // Auth timeout
        entry_req = 1'b1;
        tick(1);
        check_val("to_auth_start", int'(auth_start), 1);
        entry_req = 1'b0;
        tick(199);
        check_val("to_deny_early", int'(deny), 0);
        tick(1);
        check_val("to_deny", int'(deny), 1);
        check_val("to_gate", int'(gate_open), 0);
        tick(1);
        check_val("to_deny_pulse", int'(deny), 0);
        check_val("to_occ", int'(occupancy), 1);

        // Stray verdict and gate_clear in IDLE are ignored
        auth_done  = 1'b1;
        auth_ok    = 1'b1;
        gate_clear = 1'b1;
        tick(1);
        auth_done  = 1'b0;
        gate_clear = 1'b0;
        tick(1);
        check_val("idle_verdict_gate", int'(gate_open), 0);
        check_val("idle_clear_occ", int'(occupancy), 1);

        // Fill the lot
        for (int k = 2; k <= 8; k++) do_entry_good(k);
        check_val("fill_full", int'(lot_full), 1);

        // Full lot: entry ignored, exit served even with entry held
        entry_req = 1'b1;
        tick(3);
        check_val("full_no_auth", int'(auth_start), 0);
        check_val("full_no_gate", int'(gate_open), 0);
        exit_req = 1'b1;
        tick(1);
        check_val("full_exit_grant", int'(exit_grant), 1);
        check_val("full_entry_grant", int'(entry_grant), 0);
        entry_req  = 1'b0;
        exit_req   = 1'b0;
        gate_clear = 1'b1;
        tick(1);
        gate_clear = 1'b0;
        check_val("full_exit_occ", int'(occupancy), 7);
        check_val("full_cleared", int'(lot_full), 0);
        tick(10);

        // Down to 2, then one entry so the entrance lane was served last
        for (int k = 6; k >= 2; k--) do_exit(k);
        do_entry_good(3);

        // Contention with occupancy 3: exit, entry, exit
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick(1);
        check_val("rr1_exit", int'(exit_grant), 1);
        check_val("rr1_no_auth", int'(auth_start), 0);
        gate_clear = 1'b1;
        tick(1);
        gate_clear = 1'b0;
        check_val("rr1_occ", int'(occupancy), 2);
        tick(11);
        check_val("rr2_auth_start", int'(auth_start), 1);
        check_val("rr2_no_exit", int'(exit_grant), 0);
        tick(1);
        auth_done = 1'b1;
        auth_ok   = 1'b1;
        tick(1);
        auth_done = 1'b0;
        check_val("rr2_entry", int'(entry_grant), 1);
        gate_clear = 1'b1;
        tick(1);
        gate_clear = 1'b0;
        check_val("rr2_occ", int'(occupancy), 3);
        tick(11);
        check_val("rr3_exit", int'(exit_grant), 1);
        entry_req = 1'b0;
        exit_req  = 1'b0;

        // Open timeout: gate closes after 50 cycles, occupancy unchanged
        tick(49);
        check_val("otmo_still_open", int'(gate_open), 1);
        tick(1);
        check_val("otmo_closed", int'(gate_open), 0);
        check_val("otmo_grant", int'(exit_grant), 0);
        check_val("otmo_occ", int'(occupancy), 3);
        tick(10);

        // Reset while the gate is open for an entry
        entry_req = 1'b1;
        tick(1);
        entry_req = 1'b0;
        auth_done = 1'b1;
        auth_ok   = 1'b1;
        tick(1);
        auth_done = 1'b0;
        check_val("midrst_open", int'(gate_open), 1);
        reset = 1'b1;
        tick(1);
        check_val("midrst_gate", int'(gate_open), 0);
        check_val("midrst_grant", int'(entry_grant), 0);
        check_val("midrst_occ", int'(occupancy), 0);
        check_val("midrst_empty", int'(lot_empty), 1);
        reset = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
